logic_gate_pipe: RTL and testbench
==================================

// Module: logic_gate_pipe
// PURPOSE
//  Parametrised, registered multi-operand bitwise logic unit; successor to single-bit combinational gates.
//  Folds NUM_IN operands of WIDTH bits through an op-selected gate function.
//  Result leaves through one output register with valid/ready flow control.
//  Used as the generic gate primitive in datapaths, with a completed-operation counter for bench/debug.
// PARAMETERS
//  WIDTH   8  operand/result width in bits (>=1)
//  NUM_IN  2  operands per transaction (2..8)
//  CNT_W   16 width of completed-operation counter
// PORTS
//  clk        in   1             single clock; all state on rising edge
//  rst        in   1             asynchronous, active-high reset
//  in_valid   in   1             input transaction present
//  in_ready   out  1             unit can accept this cycle
//  in_op      in   3             gate select (encodings below)
//  in_data    in   NUM_IN*WIDTH  operand k at [k*WIDTH +: WIDTH]
//  out_valid  out  1             registered result held
//  out_ready  in   1             downstream accepts
//  out_data   out  WIDTH         result
//  out_zero   out  1             out_data == 0
//  out_op     out  3             op that produced out_data
//  cnt_clr    in   1             synchronous clear of op_count
//  op_count   out  CNT_W         results drained (out_valid && out_ready), wraps
// BEHAVIOUR
//  Op encodings (fold over all operands 0..NUM_IN-1):
//   0 AND, 1 OR, 2 XOR, 3 NAND (~AND), 4 NOR (~OR), 5 XNOR (~XOR),
//   6 ANDN = op0 & ~(OR of op1..opN-1), 7 PASS = op0.
//  All ops bitwise, result exactly WIDTH bits; no arithmetic, no carries.
//  Reset (async, any time): out_valid=0, out_data=0, out_zero=0, out_op=0, op_count=0; pending result discarded.
//  in_ready = !out_valid || out_ready (combinational; one-entry pipe, no skid).
//  Accept = in_valid && in_ready. On accept: result, zero flag, op registered; out_valid=1 next cycle. Latency 1.
//  Backpressure: out_valid && !out_ready -> out_data/out_zero/out_op stable, in_ready=0.
//  Drain without accept: out_valid -> 0 next cycle; out_data keeps last value.
//  Simultaneous drain + accept: new result replaces old in same edge; out_valid stays 1; full throughput.
//  in_data/in_op ignored when not accepted.
//  op_count: +1 on each drain; wraps from 2^CNT_W-1 to 0.
//  cnt_clr: op_count=0 next cycle; clear wins over coincident drain (result still delivered, not counted).
//  No illegal ops; no error outputs.
// STRUCTURE
//  Shared package logic_gate_pkg: op encoding constants OP_AND..OP_PASS (3-bit).
//  Sub-module logic_gate_fold: purely combinational op/operand fold (WIDTH, NUM_IN params).
//  Top: instantiates fold, owns output register, handshake and counter.
// TESTING (WIDTH=8, NUM_IN=2, CNT_W=4 unless noted)
//  Reset mid-stream: rst pulsed while out_valid=1 -> all outputs 0 immediately, in_ready=1.
//  All ops, A=8'hF0 B=8'h3C, out_ready=1 -> AND 30, OR FC, XOR CC, NAND CF, NOR 03, XNOR 33, ANDN C0, PASS F0; each 1 cycle later.
//  Zero flag: AND of 8'h0F,8'hF0 -> out_data=00, out_zero=1; then OR -> FF, out_zero=0.
//  Backpressure: out_ready=0 3 cycles with in_valid=1 -> in_ready=0, output held; release -> one drain, next input taken same edge.
//  Streaming 18 back-to-back ops, out_ready=1 -> one result/cycle, op_count wraps 15->0, ends at 2.
//  NUM_IN=4, XOR of 01,02,04,08 -> 0F; cnt_clr coincident with drain -> op_count=0.

Source files
------------

// File: rtl/logic_gate_pkg.sv
// Shared definitions for the registered multi-operand gate unit.
// The op codes are 3 bits wide and are shared by the fold logic and the bench.
package logic_gate_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'd0;
    localparam op_t OP_OR   = 3'd1;
    localparam op_t OP_XOR  = 3'd2;
    localparam op_t OP_NAND = 3'd3;
    localparam op_t OP_NOR  = 3'd4;
    localparam op_t OP_XNOR = 3'd5;
    localparam op_t OP_ANDN = 3'd6;
    localparam op_t OP_PASS = 3'd7;

endpackage

// File: rtl/logic_gate_fold.sv
// Combinational fold of NUM_IN operands through the selected bitwise gate.
// Operand k sits at data_i[k*WIDTH +: WIDTH].
module logic_gate_fold
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 2
) (
    input  logic [2:0]              op_i,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]        result_o
);

    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] xor_r;
    logic [WIDTH-1:0] or_rest;

    always_comb begin
        and_r   = data_i[WIDTH-1:0];
        or_r    = data_i[WIDTH-1:0];
        xor_r   = data_i[WIDTH-1:0];
        or_rest = '0;
        for (int unsigned k = 1; k < NUM_IN; k++) begin
            and_r   = and_r & data_i[k*WIDTH +: WIDTH];
            or_r    = or_r | data_i[k*WIDTH +: WIDTH];
            xor_r   = xor_r ^ data_i[k*WIDTH +: WIDTH];
            // ANDN masks operand 0 with everything except operand 0
            or_rest = or_rest | data_i[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_AND:  result_o = and_r;
            OP_OR:   result_o = or_r;
            OP_XOR:  result_o = xor_r;
            OP_NAND: result_o = ~and_r;
            OP_NOR:  result_o = ~or_r;
            OP_XNOR: result_o = ~xor_r;
            OP_ANDN: result_o = data_i[WIDTH-1:0] & ~or_rest;
            OP_PASS: result_o = data_i[WIDTH-1:0];
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/logic_gate_pipe.sv
// Registered multi-operand gate unit: one-entry output register with valid/ready
// handshake and a wrapping count of drained results.
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              in_op,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_zero,
    output logic [2:0]              out_op,
    input  logic                    cnt_clr,
    output logic [CNT_W-1:0]        op_count
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] fold_res;
    logic             accept;
    logic             drain;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic_gate_fold #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_fold (
        .op_i     (in_op),
        .data_i   (in_data),
        .result_o (fold_res)
    );

    // No skid buffer: a held result blocks input unless it drains this cycle
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = valid_q && out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        zero_d  = zero_q;
        op_d    = op_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = fold_res;
            zero_d  = (fold_res == '0);
            op_d    = in_op;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (drain) begin
            cnt_d = cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            zero_q  <= zero_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_zero  = zero_q;
    assign out_op    = op_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe: a 2-operand instance and a 4-operand instance,
// both with a 4-bit counter so wrap-around is reachable quickly.
module tb_logic_gate_pipe;

    logic clk;
    logic rst;

    logic        in_valid, in_ready, out_valid, out_ready, out_zero, cnt_clr;
    logic [2:0]  in_op, out_op;
    logic [15:0] in_data;
    logic [7:0]  out_data;
    logic [3:0]  op_count;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, out_zero4, cnt_clr4;
    logic [2:0]  in_op4, out_op4;
    logic [31:0] in_data4;
    logic [7:0]  out_data4;
    logic [3:0]  op_count4;

    int checks = 0;
    int errors = 0;

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_op    (out_op),
        .cnt_clr   (cnt_clr),
        .op_count  (op_count)
    );

    logic_gate_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_op     (in_op4),
        .in_data   (in_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (out_data4),
        .out_zero  (out_zero4),
        .out_op    (out_op4),
        .cnt_clr   (cnt_clr4),
        .op_count  (op_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_zero !== 1'b0 ||
            out_op !== 3'd0 || op_count !== 4'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h z=%b op=%0d cnt=%0d rdy=%b, want 0 00 0 0 0 1",
                     out_valid, out_data, out_zero, out_op, op_count, in_ready);
        end
        checks++;
        if (out_valid4 !== 1'b0 || op_count4 !== 4'd0 || in_ready4 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state4: got v=%b cnt=%0d rdy=%b, want 0 0 1",
                     out_valid4, op_count4, in_ready4);
        end
    endtask

    task automatic test_all_ops();
        logic [7:0] exp [8];
        exp[0] = 8'h30; exp[1] = 8'hFC; exp[2] = 8'hCC; exp[3] = 8'hCF;
        exp[4] = 8'h03; exp[5] = 8'h33; exp[6] = 8'hC0; exp[7] = 8'hF0;
        out_ready = 1'b1;
        in_data   = {8'h3C, 8'hF0};
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_op    = 3'(k);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[k] || out_op !== 3'(k)) begin
                errors++;
                $display("FAIL all_ops op%0d: got v=%b d=%h op=%0d, want 1 %h %0d",
                         k, out_valid, out_data, out_op, exp[k], k);
            end
        end
    endtask

    task automatic test_zero_flag();
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_data  = {8'hF0, 8'h0F};
        @(negedge clk);
        checks++;
        if (out_data !== 8'h00 || out_zero !== 1'b1) begin
            errors++;
            $display("FAIL zero_set: got d=%h z=%b, want 00 1", out_data, out_zero);
        end
        in_op = 3'd1;
        @(negedge clk);
        checks++;
        if (out_data !== 8'hFF || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL zero_clr: got d=%h z=%b, want FF 0", out_data, out_zero);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'hFF) begin
            errors++;
            $display("FAIL drain_idle: got v=%b d=%h, want 0 FF", out_valid, out_data);
        end
    endtask

    task automatic test_backpressure();
        cnt_clr   = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd0;
        in_data   = {8'h3C, 8'hF0};
        @(negedge clk);
        cnt_clr = 1'b0;
        in_op   = 3'd1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h30 ||
                out_op !== 3'd0 || op_count !== 4'd0) begin
                errors++;
                $display("FAIL bp_hold%0d: got rdy=%b v=%b d=%h op=%0d cnt=%0d, want 0 1 30 0 0",
                         i, in_ready, out_valid, out_data, out_op, op_count);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b, want 1", in_ready);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hFC || out_op !== 3'd1 || op_count !== 4'd1) begin
            errors++;
            $display("FAIL bp_swap: got v=%b d=%h op=%0d cnt=%0d, want 1 FC 1 1",
                     out_valid, out_data, out_op, op_count);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'hFC || op_count !== 4'd2) begin
            errors++;
            $display("FAIL bp_drain: got v=%b d=%h cnt=%0d, want 0 FC 2",
                     out_valid, out_data, op_count);
        end
    endtask

    task automatic test_back_to_back();
        cnt_clr   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        in_op   = 3'd2;
        for (int i = 1; i <= 18; i++) begin
            in_valid = 1'b1;
            in_data  = {8'hFF, 8'(i)};
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== (8'(i) ^ 8'hFF) ||
                op_count !== 4'((i - 1) % 16)) begin
                errors++;
                $display("FAIL stream%0d: got v=%b d=%h cnt=%0d, want 1 %h %0d",
                         i, out_valid, out_data, op_count, 8'(i) ^ 8'hFF, (i - 1) % 16);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || op_count !== 4'd2) begin
            errors++;
            $display("FAIL stream_end: got v=%b cnt=%0d, want 0 2", out_valid, op_count);
        end
    endtask

    task automatic test_num_in4();
        out_ready4 = 1'b1;
        in_valid4  = 1'b1;
        in_op4     = 3'd2;
        in_data4   = {8'h08, 8'h04, 8'h02, 8'h01};
        @(negedge clk);
        checks++;
        if (out_valid4 !== 1'b1 || out_data4 !== 8'h0F || out_zero4 !== 1'b0) begin
            errors++;
            $display("FAIL n4_xor: got v=%b d=%h z=%b, want 1 0F 0", out_valid4, out_data4, out_zero4);
        end
        in_op4   = 3'd6;
        in_data4 = {8'h04, 8'h02, 8'h01, 8'hFF};
        @(negedge clk);
        checks++;
        if (out_data4 !== 8'hF8 || out_op4 !== 3'd6 || op_count4 !== 4'd1) begin
            errors++;
            $display("FAIL n4_andn: got d=%h op=%0d cnt=%0d, want F8 6 1", out_data4, out_op4, op_count4);
        end
        in_valid4 = 1'b0;
        cnt_clr4  = 1'b1;
        @(negedge clk);
        cnt_clr4 = 1'b0;
        checks++;
        if (out_valid4 !== 1'b0 || op_count4 !== 4'd0 || out_data4 !== 8'hF8) begin
            errors++;
            $display("FAIL n4_clr_wins: got v=%b cnt=%0d d=%h, want 0 0 F8",
                     out_valid4, op_count4, out_data4);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd7;
        in_data   = {8'h00, 8'hA5};
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || op_count !== 4'd2) begin
            errors++;
            $display("FAIL pre_reset: got v=%b d=%h cnt=%0d, want 1 A5 2", out_valid, out_data, op_count);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_zero !== 1'b0 || out_op !== 3'd0 ||
            op_count !== 4'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got v=%b d=%h z=%b op=%0d cnt=%0d rdy=%b, want 0 00 0 0 0 1",
                     out_valid, out_data, out_zero, out_op, op_count, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL post_reset: got v=%b d=%h, want 0 00", out_valid, out_data);
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_op      = 3'd0;
        in_data    = '0;
        out_ready  = 1'b0;
        cnt_clr    = 1'b0;
        in_valid4  = 1'b0;
        in_op4     = 3'd0;
        in_data4   = '0;
        out_ready4 = 1'b0;
        cnt_clr4   = 1'b0;
        #12 rst = 1'b0;

        test_reset();
        test_all_ops();
        test_zero_flag();
        test_backpressure();
        test_back_to_back();
        test_num_in4();
        test_reset_midstream();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
